// File: rtl/wb_master_cmd.sv
// Wishbone classic single-transfer initiator: valid/ready command in,
// one bus cycle out, completion/read-data response back.
// Optional bus timeout abort: define WB_MASTER_TIMEOUT_EN.
module wb_master_cmd #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic                  cmd_lock_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic                  wb_lock_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       term;

  assign term = wb_ack_i | wb_err_i;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = (to_cnt == TO_LAST);

  // Count BUS cycles without termination; cleared on BUS entry
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
    end else if (state != BUS) begin
      to_cnt <= '0;
    end else if (!term && !to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic to_hit;

  assign to_hit = 1'b0;
`endif

  // Transfer FSM with all outputs registered
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_lock_o   <= 1'b0;
      wb_addr_o   <= '0;
      wb_dat_o    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            state       <= BUS;
            cmd_ready_o <= 1'b0;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            wb_we_o     <= cmd_we_i;
            wb_lock_o   <= cmd_lock_i;
            wb_addr_o   <= cmd_addr_i;
            wb_dat_o    <= cmd_we_i ? cmd_dat_i : '0;
          end
        end
        BUS: begin
          if (term || to_hit) begin
            state       <= RESP;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_lock_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= wb_err_i | ~term;
            rsp_dat_o   <= (wb_ack_i && !wb_err_i && !wb_we_o) ?
                           wb_dat_i : '0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          wb_cyc_o    <= 1'b0;
          wb_stb_o    <= 1'b0;
          wb_we_o     <= 1'b0;
          wb_lock_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_cmd.sv
// Directed bench for wb_master_cmd.
// Timeout steps follow WB_MASTER_TIMEOUT_EN.
module tb_wb_master_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_dat;
  logic        cmd_lock;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        lock;
  logic [4:0]  addr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;

  int checks = 0;
  int errs   = 0;
  int n;

  always #5 clk = ~clk;

  wb_master_cmd dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_dat_i   (cmd_dat),
    .cmd_lock_i  (cmd_lock),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wb_cyc_o    (cyc),
    .wb_stb_o    (stb),
    .wb_we_o     (we),
    .wb_lock_o   (lock),
    .wb_addr_o   (addr),
    .wb_dat_o    (dat_o),
    .wb_dat_i    (dat_i),
    .wb_ack_i    (ack),
    .wb_err_i    (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic l);
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_addr  = a;
    cmd_dat   = d;
    cmd_lock  = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0;
    cmd_dat = 0; cmd_lock = 0; rsp_ready = 0;
    dat_i = 0; ack = 0; err = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rvalid", 32'(rsp_valid), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rdat", rsp_dat, 32'd0);

    // zero-wait write
    issue(1'b1, 5'h03, 32'hDEADBEEF, 1'b0);
    chk("w_cyc", 32'(cyc), 32'd1);
    chk("w_stb", 32'(stb), 32'd1);
    chk("w_we", 32'(we), 32'd1);
    chk("w_addr", 32'(addr), 32'h03);
    chk("w_dat", dat_o, 32'hDEADBEEF);
    chk("w_ready", 32'(cmd_ready), 32'd0);
    chk("w_norsp", 32'(rsp_valid), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("w_stb_off", 32'(stb), 32'd0);
    chk("w_we_off", 32'(we), 32'd0);
    chk("w_rvalid", 32'(rsp_valid), 32'd1);
    chk("w_rerr", 32'(rsp_err), 32'd0);
    chk("w_rdat", rsp_dat, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w_done_rv", 32'(rsp_valid), 32'd0);
    chk("w_done_rdy", 32'(cmd_ready), 32'd1);

    // waited read, 3 wait states
    issue(1'b0, 5'h1F, 32'hAAAA5555, 1'b1);
    chk("r_addr", 32'(addr), 32'h1F);
    chk("r_dat0", dat_o, 32'd0);
    chk("r_lock", 32'(lock), 32'd1);
    chk("r_we", 32'(we), 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (stb) n++;
      tick();
    end
    chk("r_stb_wait", 32'(stb), 32'd1);
    if (stb) n++;
    ack = 1'b1;
    dat_i = 32'h12345678;
    tick();
    ack = 1'b0;
    dat_i = 32'h0;
    chk("r_stb_cycles", 32'(n), 32'd4);
    chk("r_stb_off", 32'(stb), 32'd0);
    chk("r_lock_off", 32'(lock), 32'd0);
    chk("r_rvalid", 32'(rsp_valid), 32'd1);
    chk("r_rdat", rsp_dat, 32'h12345678);

    // backpressure, stray ack and ignored command
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 5'h05;
    cmd_dat = 32'h55;
    for (int i = 0; i < 5; i++) begin
      ack = (i == 2);
      dat_i = 32'hFFFF0000;
      tick();
      chk("bp_rvalid", 32'(rsp_valid), 32'd1);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_cyc", 32'(cyc), 32'd0);
      chk("bp_rdat", rsp_dat, 32'h12345678);
    end
    ack = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_rv", 32'(rsp_valid), 32'd0);
    chk("bp_idle_rdy", 32'(cmd_ready), 32'd1);
    chk("bp_hold_rdat", rsp_dat, 32'h12345678);
    tick();
    chk("bp_no_accept", 32'(cyc), 32'd0);

    // err and ack together on a read
    issue(1'b0, 5'h0A, 32'h0, 1'b0);
    ack = 1'b1; err = 1'b1; dat_i = 32'hFFFFFFFF;
    tick();
    ack = 1'b0; err = 1'b0; dat_i = 32'h0;
    chk("e_rvalid", 32'(rsp_valid), 32'd1);
    chk("e_rerr", 32'(rsp_err), 32'd1);
    chk("e_rdat", rsp_dat, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("e_hold_err", 32'(rsp_err), 32'd1);
    issue(1'b1, 5'h11, 32'h0BADF00D, 1'b0);
    chk("e2_dat", dat_o, 32'h0BADF00D);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("e2_rerr", 32'(rsp_err), 32'd0);
    chk("e2_rvalid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // reset mid-transfer
    issue(1'b0, 5'h07, 32'h0, 1'b1);
    chk("mr_cyc_on", 32'(cyc), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_cyc", 32'(cyc), 32'd0);
    chk("mr_stb", 32'(stb), 32'd0);
    chk("mr_lock", 32'(lock), 32'd0);
    chk("mr_ready", 32'(cmd_ready), 32'd1);
    chk("mr_addr", 32'(addr), 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1;
      tick();
      if (rsp_valid) n++;
    end
    ack = 1'b0;
    chk("mr_no_rsp", 32'(n), 32'd0);

    // silent slave
    issue(1'b0, 5'h02, 32'h0, 1'b0);
`ifdef WB_MASTER_TIMEOUT_EN
    n = 0;
    while (stb && n < 120) begin
      n++;
      tick();
    end
    chk("to_stb_cycles", 32'(n), 32'd16);
    chk("to_rvalid", 32'(rsp_valid), 32'd1);
    chk("to_rerr", 32'(rsp_err), 32'd1);
    chk("to_rdat", rsp_dat, 32'd0);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("nto_stb", 32'(stb), 32'd1);
    chk("nto_rvalid", 32'(rsp_valid), 32'd0);
    ack = 1'b1;
    dat_i = 32'h00C0FFEE;
    tick();
    ack = 1'b0;
    chk("nto_rdat", rsp_dat, 32'h00C0FFEE);
    chk("nto_rerr", 32'(rsp_err), 32'd0);
`endif
    rsp_ready = 1'b1;
    tick();
    chk("end_ready", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wb_master_cmd.md
Name: wb_master_cmd

Overview:
- Wishbone classic single-transfer initiator for the DDS register and waveform-memory space.
- Converts a simple valid/ready command stream into Wishbone write or read cycles, then returns a completion or read-data response.
- Sits between a host-side controller (UART or SPI bridge, or a test sequencer) and the DDS Wishbone slave interface.

Parameters:
- DATA_WIDTH, 32, width of command/response data and Wishbone data buses.
- ADDR_WIDTH, 5, width of command address and Wishbone address.
- TIMEOUT_CYCLES, 16, bus cycles to wait for ack/err before abort (used only with the optional feature); must be >= 2.

Ports:
- wb_clk_i  in  1  system clock, all logic on rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_dat_i  in  DATA_WIDTH  write data.
- cmd_lock_i  in  1  request bus lock for this transfer.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i.
- rsp_dat_o  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err_o  out  1  transfer ended by wb_err_i or timeout.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_lock_o  out  1  Wishbone lock.
- wb_addr_o  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.

Behaviour:
- Interface: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- All outputs are registered.
- FSM states:
  - IDLE: cmd_ready_o=1.
  - BUS: cyc=stb=1.
  - RESP: rsp_valid_o=1.
- Reset values (all outputs, state = IDLE):
  - cmd_ready_o=1.
  - rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0.
  - wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o = 0.
  - wb_addr_o=0, wb_dat_o=0.
- IDLE -> BUS on accept edge:
  - Latch cmd_we_i, cmd_addr_i and cmd_lock_i onto wb_we_o, wb_addr_o and wb_lock_o.
  - Latch cmd_dat_i onto wb_dat_o for writes; wb_dat_o=0 for reads.
  - cyc/stb go high after the same edge; cmd_ready_o drops.
- In BUS, address, data, we and lock are held stable until termination.
- BUS -> RESP at the first edge sampling wb_ack_i | wb_err_i:
  - cyc, stb, lock and we drop after that edge.
  - rsp_valid_o rises after that edge.
  - rsp_dat_o = wb_dat_i if read with ack; otherwise 0.
  - rsp_err_o = wb_err_i.
  - If ack and err are both high, err wins: rsp_err_o=1, rsp_dat_o=0.
- Minimum latency: accept edge to rsp_valid_o = 2 edges when the slave acks in the first stb cycle.
- RESP -> IDLE on the edge with rsp_ready_i=1:
  - rsp_valid_o drops and cmd_ready_o rises after that edge.
  - rsp_dat_o and rsp_err_o hold their values until the next response.
- Ordering and stray inputs:
  - One outstanding transfer at a time; no new command is accepted while in BUS or RESP.
  - wb_ack_i or wb_err_i outside BUS is ignored.
  - cmd_valid_i with cmd_ready_o=0 is ignored; the source must hold the command.
- Reset mid-transfer: all outputs return to reset values after the reset edge. The in-flight transfer is dropped and no response is issued.

Optional Feature:
- Macro WB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on BUS entry and increments each BUS cycle without ack/err.
  - If the counter reaches TIMEOUT_CYCLES-1 with no termination on that edge, the transfer aborts: cyc/stb drop, go to RESP with rsp_err_o=1, rsp_dat_o=0.
  - A termination on the same edge as timeout takes precedence; it is handled as a normal ack/err.
- Undefined:
  - No counter logic.
  - BUS waits indefinitely for ack/err.

Test Plan:
- Zero-wait write: cmd write addr=0x03, dat=0xDEADBEEF, slave acks in the first stb cycle.
  - Expected: wb_addr_o=0x03, wb_dat_o=0xDEADBEEF, wb_we_o=1 for exactly 1 cycle; then rsp_valid_o=1, rsp_err_o=0, rsp_dat_o=0.
- Waited read: cmd read addr=0x1F, slave acks after 3 wait cycles with wb_dat_i=0x12345678.
  - Expected: stb high for 4 cycles, rsp_dat_o=0x12345678.
- Response backpressure and stray ack: hold rsp_ready_i=0 for 5 cycles and pulse wb_ack_i during RESP.
  - Expected: rsp_valid_o stays high and cmd_ready_o stays 0; the stray ack has no effect. Release rsp_ready_i -> back to IDLE next edge.
- Error termination: slave asserts wb_err_i together with wb_ack_i on a read.
  - Expected: rsp_err_o=1, rsp_dat_o=0. Next command proceeds normally.
- Reset mid-transfer: assert wb_rst_i during BUS.
  - Expected: cyc/stb/lock=0 and cmd_ready_o=1 after the reset edge; no rsp_valid_o pulse.
- Timeout (WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never responds.
  - Expected: stb high for exactly 16 cycles, then rsp_err_o=1.
  - Without the macro: stb is still high after 100 cycles.
